// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Byte/half/word load-store adapter between the MIPS datapath and
//               a word-wide DataMemory, with sub-word read-modify-write and
//               sticky misalignment / range trapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h10010000,
    parameter int          MEMORY_DEPTH = 1024,
    parameter int          ADDR_BITS    = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Stall,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  Misaligned,
    output logic [31:0]           BadAddr,
    input  logic                  ClearExc
);

    localparam logic [31:0] c_LIMIT = 32'(4 * MEMORY_DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [DATA_WIDTH-1:0]   r_word;
    logic [ADDR_BITS-1:0]    r_idx;
    logic [1:0]              r_lane;
    logic [1:0]              r_size;
    logic [15:0]             r_wdata;

    logic [31:0]             w_off;
    logic [ADDR_BITS-1:0]    w_idx;
    logic [1:0]              w_lane;
    logic                    w_isWord;
    logic                    w_isHalf;
    logic                    w_fault;
    logic                    w_subStore;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_stall;
    logic                    w_we;

    assign w_off    = Address - BASE_ADDR;
    assign w_idx    = w_off[ADDR_BITS+1:2];
    assign w_lane   = w_off[1:0];
    assign w_isWord = Size[1];
    assign w_isHalf = (Size == 2'b01);

    // Only IDLE looks at the request; MERGE ignores the held inputs.
    assign w_fault = (r_state == IDLE) && (MemRead || MemWrite) &&
                     ((w_isHalf && w_lane[0]) || (w_isWord && (w_lane != 2'b00)) ||
                      (w_off >= c_LIMIT));
    assign w_subStore = (r_state == IDLE) && MemWrite && !w_fault && !w_isWord;

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (w_lane)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = w_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (Size)
            2'b00:   w_rdata = {{24{!Unsigned && w_byte[7]}}, w_byte};
            2'b01:   w_rdata = {{16{!Unsigned && w_half[15]}}, w_half};
            default: w_rdata = mem_rdata;
        endcase
    end

    always_comb begin
        w_merged = r_word;
        if (r_size == 2'b01) begin
            if (r_lane[1]) w_merged[31:16] = r_wdata;
            else           w_merged[15:0]  = r_wdata;
        end else begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        ReadData  = '0;
        w_stall   = 1'b0;
        w_we      = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = w_idx;
        mem_wdata = WriteData;
        case (r_state)
            IDLE: begin
                if (!w_fault) begin
                    if (MemWrite) begin
                        if (w_isWord) begin
                            w_we = 1'b1;
                        end else begin
                            w_stall = 1'b1;
                            mem_re  = 1'b1;
                            w_next  = MERGE;
                        end
                    end else if (MemRead) begin
                        mem_re   = 1'b1;
                        ReadData = w_rdata;
                    end
                end
            end
            MERGE: begin
                w_we      = 1'b1;
                mem_addr  = r_idx;
                mem_wdata = w_merged;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Reset low must suppress writes immediately, not just at the next edge.
    assign Stall  = w_stall && reset;
    assign mem_we = w_we && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_lane  <= '0;
            r_size  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_subStore) begin
                r_word  <= mem_rdata;
                r_idx   <= w_idx;
                r_lane  <= w_lane;
                r_size  <= Size;
                r_wdata <= WriteData[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Misaligned <= 1'b0;
            BadAddr    <= '0;
        end else if (w_fault) begin
            Misaligned <= 1'b1;
            if (!Misaligned || ClearExc) BadAddr <= Address;
        end else if (ClearExc) begin
            Misaligned <= 1'b0;
            BadAddr    <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed table-driven and sequence checks for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, Unsigned, ClearExc;
    logic [1:0]  Size;
    logic [31:0] Address, WriteData, ReadData, mem_wdata, mem_rdata, BadAddr;
    logic [9:0]  mem_addr;
    logic        Stall, mem_we, mem_re, Misaligned;

    logic [31:0] mem [1024];
    int          errors = 0;
    int          checks = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Size(Size), .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .Misaligned(Misaligned), .BadAddr(BadAddr), .ClearExc(ClearExc)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRd;
        logic        expStall;
        logic        expWe;
        logic        expRe;
        logic [9:0]  expIdx;
        logic [31:0] expWdata;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns;
        Address = addr; WriteData = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0);
        ClearExc = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[2]    = 32'h01020304;
        mem[3]    = 32'h80F77F01;
        mem[1023] = 32'hCAFEF00D;

        //           rd wr size  uns addr          wdata         expRd         st we re idx     expWdata
        vecs[0]  = '{1, 0, 2'b10, 0, 32'h1001000C, 32'hFFFFFFFF, 32'h80F77F01, 0, 0, 1, 10'd3,    32'h0};
        vecs[1]  = '{1, 0, 2'b00, 0, 32'h1001000C, 32'hFFFFFFFF, 32'h00000001, 0, 0, 1, 10'd3,    32'h0};
        vecs[2]  = '{1, 0, 2'b00, 0, 32'h1001000D, 32'hFFFFFFFF, 32'h0000007F, 0, 0, 1, 10'd3,    32'h0};
        vecs[3]  = '{1, 0, 2'b00, 0, 32'h1001000E, 32'hFFFFFFFF, 32'hFFFFFFF7, 0, 0, 1, 10'd3,    32'h0};
        vecs[4]  = '{1, 0, 2'b00, 1, 32'h1001000E, 32'hFFFFFFFF, 32'h000000F7, 0, 0, 1, 10'd3,    32'h0};
        vecs[5]  = '{1, 0, 2'b00, 0, 32'h1001000F, 32'hFFFFFFFF, 32'hFFFFFF80, 0, 0, 1, 10'd3,    32'h0};
        vecs[6]  = '{1, 0, 2'b01, 0, 32'h1001000C, 32'hFFFFFFFF, 32'h00007F01, 0, 0, 1, 10'd3,    32'h0};
        vecs[7]  = '{1, 0, 2'b01, 0, 32'h1001000E, 32'hFFFFFFFF, 32'hFFFF80F7, 0, 0, 1, 10'd3,    32'h0};
        vecs[8]  = '{1, 0, 2'b01, 1, 32'h1001000E, 32'hFFFFFFFF, 32'h000080F7, 0, 0, 1, 10'd3,    32'h0};
        vecs[9]  = '{1, 0, 2'b11, 0, 32'h1001000C, 32'hFFFFFFFF, 32'h80F77F01, 0, 0, 1, 10'd3,    32'h0};
        vecs[10] = '{0, 0, 2'b10, 0, 32'h1001000C, 32'hFFFFFFFF, 32'h00000000, 0, 0, 0, 10'd3,    32'h0};
        vecs[11] = '{0, 1, 2'b10, 0, 32'h10010010, 32'h11223344, 32'h00000000, 0, 1, 0, 10'd4,    32'h11223344};
        vecs[12] = '{1, 1, 2'b10, 0, 32'h10010014, 32'h55667788, 32'h00000000, 0, 1, 0, 10'd5,    32'h55667788};
        vecs[13] = '{1, 0, 2'b10, 0, 32'h10010FFC, 32'hFFFFFFFF, 32'hCAFEF00D, 0, 0, 1, 10'd1023, 32'h0};

        // Reset state; a store request while reset is low must not write.
        reset = 1'b0;
        idle();
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10010000, 32'hFFFFFFFF);
        #2;
        chk("rst we", {31'b0, mem_we}, 32'h0);
        chk("rst stall", {31'b0, Stall}, 32'h0);
        chk("rst mis", {31'b0, Misaligned}, 32'h0);
        chk("rst badaddr", BadAddr, 32'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
            #1;
            chk($sformatf("v%0d rd", i), ReadData, vecs[i].expRd);
            chk($sformatf("v%0d stall", i), {31'b0, Stall}, {31'b0, vecs[i].expStall});
            chk($sformatf("v%0d we", i), {31'b0, mem_we}, {31'b0, vecs[i].expWe});
            if (!vecs[i].wr) chk($sformatf("v%0d re", i), {31'b0, mem_re}, {31'b0, vecs[i].expRe});
            if (vecs[i].expWe || vecs[i].expRe)
                chk($sformatf("v%0d idx", i), {22'b0, mem_addr}, {22'b0, vecs[i].expIdx});
            if (vecs[i].expWe) chk($sformatf("v%0d wdata", i), mem_wdata, vecs[i].expWdata);
        end
        @(negedge clk);
        idle();
        chk("tbl mem4", mem[4], 32'h11223344);
        chk("tbl mem5", mem[5], 32'h55667788);
        chk("tbl mis", {31'b0, Misaligned}, 32'h0);

        // sw then lw, same word
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10010004, 32'hDEADBEEF);
        #1;
        chk("sw we", {31'b0, mem_we}, 32'h1);
        chk("sw idx", {22'b0, mem_addr}, 32'd1);
        chk("sw stall", {31'b0, Stall}, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0);
        #1;
        chk("lw rd", ReadData, 32'hDEADBEEF);

        // sb: one stall cycle then merged write
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h10010005, 32'h000000AA);
        #1;
        chk("sb stall", {31'b0, Stall}, 32'h1);
        chk("sb we0", {31'b0, mem_we}, 32'h0);
        chk("sb re0", {31'b0, mem_re}, 32'h1);
        @(negedge clk);
        #1;
        chk("sb stall1", {31'b0, Stall}, 32'h0);
        chk("sb we1", {31'b0, mem_we}, 32'h1);
        chk("sb idx1", {22'b0, mem_addr}, 32'd1);
        chk("sb wdata", mem_wdata, 32'hDEADAAEF);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h10010005, 32'h0);
        #1;
        chk("lb", ReadData, 32'hFFFFFFAA);
        Unsigned = 1'b1;
        #1;
        chk("lbu", ReadData, 32'h000000AA);

        // sh upper half, then halfword loads
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h10010006, 32'h00001234);
        #1;
        chk("sh stall", {31'b0, Stall}, 32'h1);
        @(negedge clk);
        #1;
        chk("sh wdata", mem_wdata, 32'h1234AAEF);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h10010006, 32'h0);
        #1;
        chk("lh hi", ReadData, 32'h00001234);
        Address = 32'h10010004;
        #1;
        chk("lh lo", ReadData, 32'hFFFFAAEF);

        // misaligned faults, sticky first address, clear
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10010002, 32'h0);
        #1;
        chk("mis lw rd", ReadData, 32'h0);
        chk("mis lw we", {31'b0, mem_we}, 32'h0);
        chk("mis lw stall", {31'b0, Stall}, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h10010001, 32'hFFFF);
        #1;
        chk("mis flag", {31'b0, Misaligned}, 32'h1);
        chk("mis bad", BadAddr, 32'h10010002);
        chk("mis sh we", {31'b0, mem_we}, 32'h0);
        chk("mis sh stall", {31'b0, Stall}, 32'h0);
        @(negedge clk);
        idle();
        #1;
        chk("mis bad kept", BadAddr, 32'h10010002);
        ClearExc = 1'b1;
        @(negedge clk);
        #1;
        chk("clr flag", {31'b0, Misaligned}, 32'h0);
        chk("clr bad", BadAddr, 32'h0);
        // clear and new fault together: fault wins
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h10010003, 32'h0);
        @(negedge clk);
        idle();
        #1;
        chk("clrwin flag", {31'b0, Misaligned}, 32'h1);
        chk("clrwin bad", BadAddr, 32'h10010003);
        ClearExc = 1'b1;
        @(negedge clk);
        idle();

        // out of range sub-word store
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h10011000, 32'h55);
        #1;
        chk("oor stall", {31'b0, Stall}, 32'h0);
        chk("oor we", {31'b0, mem_we}, 32'h0);
        @(negedge clk);
        idle();
        #1;
        chk("oor flag", {31'b0, Misaligned}, 32'h1);
        chk("oor bad", BadAddr, 32'h10011000);
        ClearExc = 1'b1;
        @(negedge clk);
        idle();

        // reset during MERGE abandons the write
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h10010008, 32'h00000055);
        #1;
        chk("rm stall", {31'b0, Stall}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rm we", {31'b0, mem_we}, 32'h0);
        chk("rm stall0", {31'b0, Stall}, 32'h0);
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        chk("rm idle we", {31'b0, mem_we}, 32'h0);
        chk("rm mem2", mem[2], 32'h01020304);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10010008, 32'h0);
        #1;
        chk("rm lw", ReadData, 32'h01020304);
        @(negedge clk);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
